// File: rtl/cpu_alu.sv
// cpu_alu: registered ALU for the 4-bit CPU datapath.
//
// One shared ripple-carry adder handles ADD and SUB. For SUB the B operand is
// inverted and the carry-in is forced to 1, giving two's-complement subtraction,
// so carry_o = 1 means "no borrow". Logic ops and PASS clear the carry.
// Result and carry are registered, so the inputs sampled at a rising edge
// appear on the outputs right after that edge. There is no combinational path
// from the inputs to the outputs.
//
// Ports:
//   clk_i     clock, all state changes on the rising edge
//   rst_ni    synchronous active-low reset, clears result and carry
//   a_i       operand A (accumulator side)
//   b_i       operand B (memory/immediate side)
//   oc_i      operation code:
//               000 PASS, 001 XOR, 010 AND, 011 OR,
//               100/101 ADD, 110/111 SUB
//   result_o  registered result
//   carry_o   registered carry / no-borrow flag
module cpu_alu #(
  parameter int unsigned ALU_BIT_WIDTH        = 4,
  parameter int unsigned OPERATION_CODE_WIDTH = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [ALU_BIT_WIDTH-1:0]        a_i,
  input  logic [ALU_BIT_WIDTH-1:0]        b_i,
  input  logic [OPERATION_CODE_WIDTH-1:0] oc_i,
  output logic [ALU_BIT_WIDTH-1:0]        result_o,
  output logic                            carry_o
);

  typedef enum logic [2:0] {
    OpPass   = 3'b000,
    OpXor    = 3'b001,
    OpAnd    = 3'b010,
    OpOr     = 3'b011,
    OpAddMem = 3'b100,
    OpAddImm = 3'b101,
    OpSubImm = 3'b110,
    OpSubMem = 3'b111
  } op_e;

  logic                     w_sub;
  logic [ALU_BIT_WIDTH-1:0] w_b_eff;
  logic [ALU_BIT_WIDTH-1:0] w_sum;
  logic [ALU_BIT_WIDTH:0]   w_carry;
  logic [ALU_BIT_WIDTH-1:0] w_result_d;
  logic                     w_carry_d;
  op_e                      w_op;

  logic [ALU_BIT_WIDTH-1:0] r_result;
  logic                     r_carry;

  assign w_op = op_e'(oc_i[2:0]);

  // Subtract for both SUB encodings (oc = 11x).
  assign w_sub   = oc_i[2] & oc_i[1];
  assign w_b_eff = b_i ^ {ALU_BIT_WIDTH{w_sub}};

  // Ripple-carry adder: one full adder per bit, carry-in is the subtract flag.
  always_comb begin
    w_carry    = '0;
    w_sum      = '0;
    w_carry[0] = w_sub;
    for (int unsigned i = 0; i < ALU_BIT_WIDTH; i++) begin
      w_sum[i]     = a_i[i] ^ w_b_eff[i] ^ w_carry[i];
      w_carry[i+1] = (a_i[i] & w_b_eff[i]) | (w_carry[i] & (a_i[i] ^ w_b_eff[i]));
    end
  end

  // Opcode decode and result select.
  always_comb begin
    w_result_d = '0;
    w_carry_d  = 1'b0;
    unique case (w_op)
      OpPass: w_result_d = b_i;
      OpXor:  w_result_d = a_i ^ b_i;
      OpAnd:  w_result_d = a_i & b_i;
      OpOr:   w_result_d = a_i | b_i;
      OpAddMem, OpAddImm, OpSubImm, OpSubMem: begin
        w_result_d = w_sum;
        w_carry_d  = w_carry[ALU_BIT_WIDTH];
      end
      default: begin
        w_result_d = '0;
        w_carry_d  = 1'b0;
      end
    endcase
  end

  // Output registers; reset discards any in-flight result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_result <= '0;
      r_carry  <= 1'b0;
    end else begin
      r_result <= w_result_d;
      r_carry  <= w_carry_d;
    end
  end

  assign result_o = r_result;
  assign carry_o  = r_carry;

endmodule

// File: tb/tb_cpu_alu.sv
// tb_cpu_alu: self-checking bench for cpu_alu.
// Directed vectors from a table, a reset sequence, and back-to-back
// random traffic across all opcodes with mid-cycle input toggling.
module tb_cpu_alu;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] oc;
  logic [3:0] result;
  logic       carry;

  int total;
  int bad;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] oc;
    logic [3:0] r;
    logic       c;
  } vec_t;

  typedef struct {
    logic [3:0] r;
    logic       c;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[13];

  cpu_alu #(
    .ALU_BIT_WIDTH       (4),
    .OPERATION_CODE_WIDTH(3)
  ) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .a_i     (a),
    .b_i     (b),
    .oc_i    (oc),
    .result_o(result),
    .carry_o (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic, unsigned compare for borrow.
  function automatic exp_t model(input logic [3:0] ma, input logic [3:0] mb,
                                 input logic [2:0] moc);
    exp_t       e;
    logic [4:0] s;
    e.r = 4'h0;
    e.c = 1'b0;
    case (moc)
      3'd0: e.r = mb;
      3'd1: e.r = ma ^ mb;
      3'd2: e.r = ma & mb;
      3'd3: e.r = ma | mb;
      3'd4, 3'd5: begin
        s   = {1'b0, ma} + {1'b0, mb};
        e.r = s[3:0];
        e.c = s[4];
      end
      default: begin
        e.r = ma - mb;
        e.c = (ma >= mb);
      end
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [3:0] got_r, input logic got_c,
                       input logic [3:0] exp_r, input logic exp_c);
    total++;
    if (got_r !== exp_r || got_c !== exp_c) begin
      bad++;
      $display("FAIL %s: got result=%b carry=%b, want result=%b carry=%b",
               name, got_r, got_c, exp_r, exp_c);
    end
  endtask

  // Drive one vector on the falling edge and record its expected output.
  task automatic drive(input logic [3:0] da, input logic [3:0] db, input logic [2:0] doc,
                       input logic [3:0] er, input logic ec);
    exp_t e;
    @(negedge clk);
    a  = da;
    b  = db;
    oc = doc;
    e.r = er;
    e.c = ec;
    sb_q.push_back(e);
  endtask

  // After the rising edge, pop the oldest expectation and compare.
  task automatic collect(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got result=%b carry=%b", name, result, carry);
    end else begin
      e = sb_q.pop_front();
      check(name, result, carry, e.r, e.c);
    end
  endtask

  initial begin
    exp_t e;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a     = 4'hF;
    b     = 4'hF;
    oc    = 3'b100;

    vecs[0]  = '{4'b0010, 4'b1111, 3'b100, 4'b0001, 1'b1};
    vecs[1]  = '{4'b0001, 4'b0010, 3'b101, 4'b0011, 1'b0};
    vecs[2]  = '{4'b0001, 4'b0010, 3'b111, 4'b1111, 1'b0};
    vecs[3]  = '{4'b0001, 4'b0010, 3'b110, 4'b1111, 1'b0};
    vecs[4]  = '{4'b0011, 4'b0011, 3'b110, 4'b0000, 1'b1};
    vecs[5]  = '{4'b1001, 4'b1010, 3'b001, 4'b0011, 1'b0};
    vecs[6]  = '{4'b1001, 4'b1010, 3'b010, 4'b1000, 1'b0};
    vecs[7]  = '{4'b1001, 4'b1010, 3'b011, 4'b1011, 1'b0};
    vecs[8]  = '{4'b0101, 4'b1100, 3'b000, 4'b1100, 1'b0};
    vecs[9]  = '{4'b1111, 4'b0001, 3'b100, 4'b0000, 1'b1};
    vecs[10] = '{4'b0000, 4'b0001, 3'b111, 4'b1111, 1'b0};
    vecs[11] = '{4'b0000, 4'b0000, 3'b111, 4'b0000, 1'b1};
    vecs[12] = '{4'b1111, 4'b1111, 3'b010, 4'b1111, 1'b0};

    // Reset state: inputs would give a carry, reset must win.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", result, carry, 4'b0000, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, one vector per cycle.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].oc, vecs[i].r, vecs[i].c);
      collect($sformatf("vec%0d", i));
    end

    // Mid-stream reset discards an ADD that would have produced carry 1.
    drive(4'b0010, 4'b1111, 3'b100, 4'b0001, 1'b1);
    collect("pre_reset_add");
    @(negedge clk);
    rst_n = 1'b0;
    a     = 4'b1111;
    b     = 4'b0001;
    oc    = 3'b100;
    @(posedge clk);
    #1;
    check("mid_reset", result, carry, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    a     = 4'b0001;
    b     = 4'b0001;
    oc    = 3'b100;
    e.r = 4'b0010;
    e.c = 1'b0;
    sb_q.push_back(e);
    collect("after_release");

    // Back-to-back random traffic across all opcodes; inputs toggle after
    // each edge and the registered outputs must hold.
    for (int i = 0; i < 32; i++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic [2:0] roc;
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      roc = 3'(i % 8);
      e   = model(ra, rb, roc);
      drive(ra, rb, roc, e.r, e.c);
      collect($sformatf("b2b%0d_oc%0d", i, roc));
      #1;
      a  = ~a;
      b  = 4'($urandom_range(0, 15));
      oc = oc + 3'd3;
      #1;
      check($sformatf("hold%0d", i), result, carry, e.r, e.c);
    end

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
